// File: rtl/atm_balance_arbiter.sv
// atm_balance_arbiter: owns the account balance and serialises deposit,
// withdraw and transfer-out requests with round-robin arbitration. Each
// granted transaction walks GRANT -> CHECK -> COMMIT -> DONE.
module atm_balance_arbiter #(
  parameter int BAL_W      = 8,
  parameter int AMT_W      = 6,
  parameter int INIT_BAL   = 100,
  parameter int XFER_LIMIT = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             session_en,
  input  logic             dep_req,
  input  logic [AMT_W-1:0] dep_amt,
  input  logic             wd_req,
  input  logic [AMT_W-1:0] wd_amt,
  input  logic             xfer_req,
  input  logic [AMT_W-1:0] xfer_amt,
  output logic [2:0]       grant,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err,
  output logic [BAL_W-1:0] balance,
  output logic [BAL_W-1:0] txn_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_CHECK, S_COMMIT, S_DONE} state_t;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_FUNDS = 2'b01;
  localparam logic [1:0] ST_LIMIT = 2'b10;
  localparam logic [1:0] ST_ABORT = 2'b11;

  // Requester index: 0 = dep, 1 = wd, 2 = xfer (matches grant bit order)
  state_t           state_q, state_d;
  logic [1:0]       rr_q, win_q;
  logic [2:0]       grant_q;
  logic [1:0]       err_q, st_q, st_d;
  logic [BAL_W-1:0] bal_q, cnt_q, amt_q;

  logic [2:0]       req_v;
  logic [2:0]       probe;
  logic             pick_vld;
  logic [1:0]       pick_idx;
  logic [AMT_W-1:0] amt_sel;
  logic [BAL_W:0]   sum_w;

  assign req_v = {xfer_req, wd_req, dep_req};

  // Round-robin pick: first asserted request at or after the rr pointer
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = 2'd0;
    probe    = 3'd0;
    for (int k = 0; k < 3; k++) begin
      probe = {1'b0, rr_q} + 3'(k);
      if (probe >= 3'd3) probe = probe - 3'd3;
      if (!pick_vld && req_v[probe[1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = probe[1:0];
      end
    end
  end

  // Amount mux for the current winner; the requester holds it stable
  always_comb begin
    case (win_q)
      2'd0:    amt_sel = dep_amt;
      2'd1:    amt_sel = wd_amt;
      default: amt_sel = xfer_amt;
    endcase
  end

  // Status evaluation with one extra bit so deposit overflow is visible
  always_comb begin
    sum_w = {1'b0, bal_q} + {1'b0, amt_q};
    st_d  = ST_OK;
    case (win_q)
      2'd0:    if (sum_w[BAL_W]) st_d = ST_LIMIT;
      2'd1:    if (amt_q > bal_q) st_d = ST_FUNDS;
      default: begin
        if (amt_q > BAL_W'(XFER_LIMIT)) st_d = ST_LIMIT;
        else if (amt_q > bal_q)         st_d = ST_FUNDS;
      end
    endcase
  end

  // Next-state logic; dropping the session before COMMIT aborts the txn
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (session_en && pick_vld) state_d = S_GRANT;
      S_GRANT:  state_d = session_en ? S_CHECK  : S_DONE;
      S_CHECK:  state_d = session_en ? S_COMMIT : S_DONE;
      S_COMMIT: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset overrides any in-flight update
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rr_q    <= 2'd0;
      win_q   <= 2'd0;
      grant_q <= 3'b000;
      err_q   <= ST_OK;
      st_q    <= ST_OK;
      amt_q   <= '0;
      bal_q   <= BAL_W'(INIT_BAL);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (state_d == S_GRANT) begin
            win_q   <= pick_idx;
            grant_q <= 3'b001 << pick_idx;
          end
        end
        S_GRANT: begin
          amt_q <= {{(BAL_W-AMT_W){1'b0}}, amt_sel};
          if (!session_en) err_q <= ST_ABORT;
        end
        S_CHECK: begin
          st_q <= st_d;
          if (!session_en) err_q <= ST_ABORT;
        end
        S_COMMIT: begin
          err_q <= st_q;
          if (st_q == ST_OK) begin
            cnt_q <= cnt_q + 1'b1;
            if (win_q == 2'd0) bal_q <= bal_q + amt_q;
            else               bal_q <= bal_q - amt_q;
          end
        end
        S_DONE: begin
          rr_q    <= (win_q == 2'd2) ? 2'd0 : win_q + 2'd1;
          grant_q <= 3'b000;
        end
        default: ;
      endcase
    end
  end

  assign grant   = grant_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign err     = err_q;
  assign balance = bal_q;
  assign txn_cnt = cnt_q;

endmodule

// File: tb/tb_atm_balance_arbiter.sv
// Directed bench for atm_balance_arbiter with hand-computed expectations.
module tb_atm_balance_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       session_en = 1'b1;
  logic       dep_req = 1'b0, wd_req = 1'b0, xfer_req = 1'b0;
  logic [5:0] dep_amt = '0, wd_amt = '0, xfer_amt = '0;
  logic [2:0] grant;
  logic       busy, done;
  logic [1:0] err;
  logic [7:0] balance, txn_cnt;

  int n_chk = 0;
  int n_err = 0;

  atm_balance_arbiter #(.BAL_W(8), .AMT_W(6), .INIT_BAL(100), .XFER_LIMIT(40)) dut (
    .clk(clk), .rst(rst), .session_en(session_en),
    .dep_req(dep_req), .dep_amt(dep_amt),
    .wd_req(wd_req), .wd_amt(wd_amt),
    .xfer_req(xfer_req), .xfer_amt(xfer_amt),
    .grant(grant), .busy(busy), .done(done), .err(err),
    .balance(balance), .txn_cnt(txn_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
  endtask

  task automatic set_req(input int k, input logic v, input logic [5:0] a);
    case (k)
      0: begin dep_req = v;  dep_amt = a;  end
      1: begin wd_req = v;   wd_amt = a;   end
      default: begin xfer_req = v; xfer_amt = a; end
    endcase
  endtask

  // One full transaction from IDLE; checks grant timing, done pulse and err
  task automatic txn(input string tag, input int k, input logic [5:0] a, input logic [1:0] eerr);
    set_req(k, 1'b1, a);
    step();                                          // E0
    chk({tag, ".grant"}, grant, 32'(3'b001 << k));
    chk({tag, ".busy"}, busy, 1);
    step(); step();                                  // E1, E2
    chk({tag, ".nodone"}, done, 0);
    step();                                          // E3
    chk({tag, ".done"}, done, 1);
    chk({tag, ".err"}, err, eerr);
    set_req(k, 1'b0, a);
    step();                                          // E4
    chk({tag, ".idle"}, busy, 0);
  endtask

  initial begin
    // T1 reset
    do_reset();
    chk("t1.bal", balance, 100);
    chk("t1.cnt", txn_cnt, 0);
    chk("t1.grant", grant, 0);
    chk("t1.busy", busy, 0);
    chk("t1.done", done, 0);
    chk("t1.err", err, 0);

    // T2 withdraw 30
    txn("t2", 1, 6'd30, 2'b00);
    chk("t2.bal", balance, 70);
    chk("t2.cnt", txn_cnt, 1);

    // T3 insufficient funds and transfer limit
    txn("t3a", 1, 6'd20, 2'b00);
    chk("t3a.bal", balance, 50);
    txn("t3b", 1, 6'd63, 2'b01);
    chk("t3b.bal", balance, 50);
    chk("t3b.cnt", txn_cnt, 2);
    txn("t3c", 2, 6'd41, 2'b10);
    chk("t3c.bal", balance, 50);
    chk("t3c.cnt", txn_cnt, 2);
    step();
    chk("t3.errhold", err, 2'b10);

    // Zero amount: legal, counts as a commit
    txn("z0", 0, 6'd0, 2'b00);
    chk("z0.bal", balance, 50);
    chk("z0.cnt", txn_cnt, 3);

    // T5 deposit overflow boundary
    do_reset();
    txn("t5a", 0, 6'd63, 2'b00);
    txn("t5b", 1, 6'd63, 2'b00);   // rr fairness irrelevant with one requester
    txn("t5c", 0, 6'd63, 2'b00);
    txn("t5d", 0, 6'd63, 2'b00);
    txn("t5e", 0, 6'd14, 2'b00);
    chk("t5.bal240", balance, 240);
    txn("t5f", 0, 6'd31, 2'b10);
    chk("t5f.bal", balance, 240);
    txn("t5g", 0, 6'd15, 2'b00);
    chk("t5g.bal", balance, 255);
    chk("t5g.cnt", txn_cnt, 6);

    // T4 round-robin with all requests held
    do_reset();
    dep_req = 1'b1; dep_amt = 6'd1;
    wd_req = 1'b1;  wd_amt = 6'd1;
    xfer_req = 1'b1; xfer_amt = 6'd1;
    for (int i = 0; i < 4; i++) begin
      int w;
      w = 0;
      step();
      while (grant == 3'b000 && w < 10) begin step(); w++; end
      chk("t4.grant", grant, 32'(3'b001 << (i % 3)));
      w = 0;
      while (!done && w < 10) begin step(); w++; end
      chk("t4.done", done, 1);
      step();
    end
    dep_req = 1'b0; wd_req = 1'b0; xfer_req = 1'b0;
    step(); step();
    chk("t4.bal", balance, 100);
    chk("t4.cnt", txn_cnt, 4);

    // T6 session drop during CHECK aborts
    do_reset();
    set_req(1, 1'b1, 6'd10);
    step(); step();                 // E0 GRANT, E1 CHECK
    session_en = 1'b0;
    step();                         // abort -> DONE
    chk("t6.done", done, 1);
    chk("t6.err", err, 2'b11);
    set_req(1, 1'b0, 6'd10);
    session_en = 1'b1;
    step();
    chk("t6.bal", balance, 100);
    chk("t6.cnt", txn_cnt, 0);
    chk("t6.idle", busy, 0);

    // T6 reset during COMMIT: no partial update
    set_req(1, 1'b1, 6'd10);
    step(); step(); step();         // E0, E1, E2 -> in COMMIT
    rst = 1'b0;
    step();
    rst = 1'b1;
    set_req(1, 1'b0, 6'd10);
    chk("t6r.bal", balance, 100);
    chk("t6r.cnt", txn_cnt, 0);
    chk("t6r.busy", busy, 0);
    chk("t6r.done", done, 0);
    chk("t6r.err", err, 0);
    chk("t6r.grant", grant, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
